br_puf_sequencer: RTL and testbench

//  Sequencer for one 64-stage bistable-ring PUF macro. Per request it:
//   - latches a challenge and drives it to the ring;
//   - holds the ring in reset, then releases it and waits for it to settle;
//   - samples the ring output several times and majority-votes one response bit.

---
 rtl/br_puf_pkg.sv | 26 ++
 rtl/br_sync2.sv | 25 ++
 rtl/br_puf_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_br_puf_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/br_puf_pkg.sv
// Shared types and constants for the bistable-ring PUF sequencer.
// Used by br_puf_sequencer and br_sync2.
package br_puf_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int BR_WIDTH = 64;
    localparam int ONES_W   = 8;

    // Majority decision: more than half of the voted samples were 1.
    function automatic logic majority(input logic [ONES_W-1:0] ones, input int num_samples);
        return (ones > ONES_W'(num_samples / 2));
    endfunction

    // A response is stable when every vote agreed.
    function automatic logic all_agree(input logic [ONES_W-1:0] ones, input int num_samples);
        return ((ones == {ONES_W{1'b0}}) || (ones == ONES_W'(num_samples)));
    endfunction

endpackage

// File: rtl/br_sync2.sv
// Two-flop synchroniser for the asynchronous ring output; cleared by RESET.
module br_sync2 (
    input  logic CLK,
    input  logic RESET,
    input  logic D,
    output logic Q
);

    logic meta_r;
    logic sync_r;

    // Two-stage metastability filter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= D;
            sync_r <= meta_r;
        end
    end

    assign Q = sync_r;

endmodule

// File: rtl/br_puf_sequencer.sv
// Challenge/reset/settle/sample/vote sequencer for one 64-stage bistable-ring PUF.
// Optional RESP_STABLE output enabled by defining BR_PUF_STABILITY_EN.
module br_puf_sequencer
    import br_puf_pkg::*;
#(
    parameter int RESET_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 64,
    parameter int NUM_SAMPLES   = 7,
    parameter int SAMPLE_GAP    = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic [BR_WIDTH-1:0] CHAL,
    input  logic                BR_OUT,
    output logic                BR_RESET,
    output logic [BR_WIDTH-1:0] BR_C,
    output logic                BUSY,
    output logic                RESP_VALID,
    output logic                RESP,
    output logic [ONES_W-1:0]   RESP_ONES
`ifdef BR_PUF_STABILITY_EN
    ,
    output logic                RESP_STABLE
`endif
);

    localparam int RST_W = (RESET_CYCLES  > 1) ? $clog2(RESET_CYCLES + 1)  : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SMP_W = (NUM_SAMPLES   > 1) ? $clog2(NUM_SAMPLES + 1)   : 1;
    localparam int GAP_W = (SAMPLE_GAP    > 0) ? $clog2(SAMPLE_GAP + 1)    : 1;

    if (NUM_SAMPLES % 2 == 0) begin : g_chk_odd
        $error("NUM_SAMPLES must be odd");
    end
    if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > 255)) begin : g_chk_range
        $error("NUM_SAMPLES must be in 1..255");
    end
    if (SETTLE_CYCLES < 2) begin : g_chk_settle
        $error("SETTLE_CYCLES must be at least 2");
    end
    if (RESET_CYCLES < 1) begin : g_chk_reset
        $error("RESET_CYCLES must be at least 1");
    end

    state_t              state_r, state_s;
    logic [RST_W-1:0]    rst_cnt_r, rst_cnt_s;
    logic [SET_W-1:0]    settle_cnt_r, settle_cnt_s;
    logic [GAP_W-1:0]    gap_cnt_r, gap_cnt_s;
    logic [SMP_W-1:0]    smp_cnt_r, smp_cnt_s;
    logic [ONES_W-1:0]   acc_r, acc_s;
    logic [BR_WIDTH-1:0] br_c_r, br_c_s;
    logic                br_reset_r, br_reset_s;
    logic                busy_r, busy_s;
    logic                resp_valid_r, resp_valid_s;
    logic                resp_r, resp_s;
    logic [ONES_W-1:0]   resp_ones_r, resp_ones_s;
    logic                br_sync_s;
`ifdef BR_PUF_STABILITY_EN
    logic                stable_r, stable_s;
`endif

    br_sync2 u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (BR_OUT),
        .Q     (br_sync_s)
    );

    // Next-state, counters, accumulator and challenge latch.
    always_comb begin
        state_s      = state_r;
        rst_cnt_s    = rst_cnt_r;
        settle_cnt_s = settle_cnt_r;
        gap_cnt_s    = gap_cnt_r;
        smp_cnt_s    = smp_cnt_r;
        acc_s        = acc_r;
        br_c_s       = br_c_r;
        case (state_r)
            IDLE: begin
                if (START) begin
                    br_c_s    = CHAL;
                    acc_s     = {ONES_W{1'b0}};
                    rst_cnt_s = {RST_W{1'b0}};
                    state_s   = RST;
                end else begin
                    state_s   = IDLE;
                end
            end
            RST: begin
                if (rst_cnt_r == RST_W'(RESET_CYCLES - 1)) begin
                    settle_cnt_s = {SET_W{1'b0}};
                    state_s      = SETTLE;
                end else begin
                    rst_cnt_s    = rst_cnt_r + RST_W'(1);
                end
            end
            SETTLE: begin
                if (settle_cnt_r == SET_W'(SETTLE_CYCLES - 1)) begin
                    gap_cnt_s    = {GAP_W{1'b0}};
                    smp_cnt_s    = {SMP_W{1'b0}};
                    state_s      = SAMPLE;
                end else begin
                    settle_cnt_s = settle_cnt_r + SET_W'(1);
                end
            end
            SAMPLE: begin
                // Last cycle of each window captures one vote.
                if (gap_cnt_r == GAP_W'(SAMPLE_GAP)) begin
                    acc_s     = acc_r + ONES_W'(br_sync_s);
                    gap_cnt_s = {GAP_W{1'b0}};
                    if (smp_cnt_r == SMP_W'(NUM_SAMPLES - 1)) begin
                        state_s   = DONE;
                    end else begin
                        smp_cnt_s = smp_cnt_r + SMP_W'(1);
                    end
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output values derived from the state being entered, so outputs are registered.
    always_comb begin
        br_reset_s   = 1'b1;
        busy_s       = 1'b0;
        resp_valid_s = 1'b0;
        resp_s       = resp_r;
        resp_ones_s  = resp_ones_r;
`ifdef BR_PUF_STABILITY_EN
        stable_s     = stable_r;
`endif
        case (state_s)
            IDLE: begin
                br_reset_s = 1'b1;
                busy_s     = 1'b0;
            end
            RST: begin
                br_reset_s = 1'b1;
                busy_s     = 1'b1;
            end
            SETTLE, SAMPLE: begin
                br_reset_s = 1'b0;
                busy_s     = 1'b1;
            end
            DONE: begin
                br_reset_s   = 1'b1;
                busy_s       = 1'b1;
                resp_valid_s = 1'b1;
                resp_s       = majority(acc_s, NUM_SAMPLES);
                resp_ones_s  = acc_s;
`ifdef BR_PUF_STABILITY_EN
                stable_s     = all_agree(acc_s, NUM_SAMPLES);
`endif
            end
            default: begin
                br_reset_s = 1'b1;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= IDLE;
            rst_cnt_r    <= {RST_W{1'b0}};
            settle_cnt_r <= {SET_W{1'b0}};
            gap_cnt_r    <= {GAP_W{1'b0}};
            smp_cnt_r    <= {SMP_W{1'b0}};
            acc_r        <= {ONES_W{1'b0}};
            br_c_r       <= {BR_WIDTH{1'b0}};
            br_reset_r   <= 1'b1;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_r       <= 1'b0;
            resp_ones_r  <= {ONES_W{1'b0}};
`ifdef BR_PUF_STABILITY_EN
            stable_r     <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            rst_cnt_r    <= rst_cnt_s;
            settle_cnt_r <= settle_cnt_s;
            gap_cnt_r    <= gap_cnt_s;
            smp_cnt_r    <= smp_cnt_s;
            acc_r        <= acc_s;
            br_c_r       <= br_c_s;
            br_reset_r   <= br_reset_s;
            busy_r       <= busy_s;
            resp_valid_r <= resp_valid_s;
            resp_r       <= resp_s;
            resp_ones_r  <= resp_ones_s;
`ifdef BR_PUF_STABILITY_EN
            stable_r     <= stable_s;
`endif
        end
    end

    assign BR_RESET   = br_reset_r;
    assign BR_C       = br_c_r;
    assign BUSY       = busy_r;
    assign RESP_VALID = resp_valid_r;
    assign RESP       = resp_r;
    assign RESP_ONES  = resp_ones_r;
`ifdef BR_PUF_STABILITY_EN
    assign RESP_STABLE = stable_r;
`endif

endmodule

// File: tb/tb_br_puf_sequencer.sv
// Self-checking bench for br_puf_sequencer: table-driven requests with a result
// scoreboard, plus busy-guard, back-to-back, mid-run reset and ring-model sequences.
module tb_br_puf_sequencer;
    import br_puf_pkg::*;

    logic                clk;
    logic                rst;
    logic                start;
    logic [BR_WIDTH-1:0] chal;
    logic                br_out;
    logic                br_reset;
    logic [BR_WIDTH-1:0] br_c;
    logic                busy;
    logic                resp_valid;
    logic                resp;
    logic [ONES_W-1:0]   resp_ones;
`ifdef BR_PUF_STABILITY_EN
    logic                resp_stable;
`endif

    br_puf_sequencer dut (
        .CLK        (clk),
        .RESET      (rst),
        .START      (start),
        .CHAL       (chal),
        .BR_OUT     (br_out),
        .BR_RESET   (br_reset),
        .BR_C       (br_c),
        .BUSY       (busy),
        .RESP_VALID (resp_valid),
        .RESP       (resp),
        .RESP_ONES  (resp_ones)
`ifdef BR_PUF_STABILITY_EN
        ,
        .RESP_STABLE(resp_stable)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ring: output flips on each rising edge of its reset.
    logic       use_ring;
    logic       ring_init;
    logic [7:0] ring_tog;
    logic       br_out_drv;
    initial ring_tog = 8'd0;
    always @(posedge br_reset) ring_tog <= ring_tog + 8'd1;
    assign br_out = use_ring ? (ring_init ^ ring_tog[0]) : br_out_drv;

    typedef struct {
        logic [63:0] chal;
        logic [6:0]  pattern;     // bit 6 drives the first sample window
        int          pulse_at;    // cycle of an ignored START pulse, -1 for none
        logic        exp_resp;
        logic [7:0]  exp_ones;
        logic        exp_stable;
    } vec_t;

    localparam int LAT = 90;

    int   total;
    int   passed;
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request; abort_at >= 0 asserts RESET in that cycle instead of completing.
    task automatic run_req(input vec_t v, input int abort_at, input string tag);
        vec_t e;
        int   bad;
        bad = 0;
        @(negedge clk);
        start      = 1'b1;
        chal       = v.chal;
        br_out_drv = 1'b0;
        exp_q.push_back(v);
        @(posedge clk);
        for (int c = 0; c <= LAT; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            if (c == v.pulse_at) begin
                start = 1'b1;
                chal  = 64'h1;
            end
            if (c == v.pulse_at + 1) start = 1'b0;
            if (c >= 68 && c < 89 && ((c - 68) % 3) == 0) br_out_drv = v.pattern[6 - (c - 68) / 3];
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                chk({tag, " abort br_reset"}, 64'(br_reset), 64'd1);
                chk({tag, " abort busy"}, 64'(busy), 64'd0);
                chk({tag, " abort resp_valid"}, 64'(resp_valid), 64'd0);
                chk({tag, " abort resp_ones"}, 64'(resp_ones), 64'd0);
                void'(exp_q.pop_front());
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (br_reset !== ((c < 4) || (c >= 89))) bad++;
            if (busy !== (c < LAT)) bad++;
            if (resp_valid !== (c == LAT - 1)) bad++;
            if (br_c !== v.chal) bad++;
            if (c == LAT - 1) begin
                chk({tag, " resp_valid at +90"}, 64'(resp_valid), 64'd1);
                chk({tag, " scoreboard nonempty"}, 64'(exp_q.size() > 0), 64'd1);
                if (resp_valid === 1'b1 && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk({tag, " resp"}, 64'(resp), 64'(e.exp_resp));
                    chk({tag, " resp_ones"}, 64'(resp_ones), 64'(e.exp_ones));
`ifdef BR_PUF_STABILITY_EN
                    chk({tag, " resp_stable"}, 64'(resp_stable), 64'(e.exp_stable));
`endif
                end
            end
            if (c == LAT) begin
                chk({tag, " busy after done"}, 64'(busy), 64'd0);
                chk({tag, " resp_ones held"}, 64'(resp_ones), 64'(v.exp_ones));
            end
        end
        chk({tag, " profile"}, 64'(bad), 64'd0);
    endtask

    vec_t vecs[5];
    vec_t rv;
    int   times[$];
    int   extra;

    initial begin
        total      = 0;
        passed     = 0;
        use_ring   = 1'b0;
        ring_init  = 1'b0;
        br_out_drv = 1'b0;
        start      = 1'b0;
        chal       = 64'h0;
        rst        = 1'b1;

        vecs[0] = '{64'hDEAD_BEEF_0123_4567, 7'b1111111, -1, 1'b1, 8'd7, 1'b1};
        vecs[1] = '{64'hA5A5_5A5A_F00D_CAFE, 7'b1010100, -1, 1'b0, 8'd3, 1'b0};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 7'b1101010, 10, 1'b1, 8'd4, 1'b0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'b0000000, -1, 1'b0, 8'd0, 1'b1};
        vecs[4] = '{64'h8000_0000_0000_0001, 7'b0000001, -1, 1'b0, 8'd1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset br_reset", 64'(br_reset), 64'd1);
        chk("reset br_c", br_c, 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        chk("reset resp", 64'(resp), 64'd0);
        chk("reset resp_ones", 64'(resp_ones), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_req(vecs[i], -1, $sformatf("vec%0d", i));
            if (vecs[i].pulse_at >= 0) begin
                extra = 0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (resp_valid === 1'b1) extra++;
                end
                chk("busy guard no extra resp", 64'(extra), 64'd0);
            end
        end

        // START held high: one response every LAT+1 cycles.
        @(negedge clk);
        br_out_drv = 1'b0;
        start      = 1'b1;
        chal       = 64'h55;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) times.push_back(k);
        end
        start = 1'b0;
        chk("held start pulse count", 64'(times.size() >= 3), 64'd1);
        if (times.size() >= 3) begin
            chk("held start period 1", 64'(times[1] - times[0]), 64'd91);
            chk("held start period 2", 64'(times[2] - times[1]), 64'd91);
        end
        repeat (100) @(negedge clk);
        chk("held start idle", 64'(busy), 64'd0);

        // Reset in SAMPLE discards the run; a fresh request then completes.
        run_req(vecs[0], -1, "pre_abort");
        run_req(vecs[1], 75, "abort");
        run_req(vecs[2], -1, "post_abort");

        // Ring model: first request sees 1, its DONE flips the ring to 0.
        use_ring  = 1'b1;
        ring_init = 1'b1 ^ ring_tog[0];
        rv = '{64'h0F0F_0F0F_0F0F_0F0F, 7'b0000000, -1, 1'b1, 8'd7, 1'b1};
        run_req(rv, -1, "ring1");
        rv = '{64'hF0F0_F0F0_F0F0_F0F0, 7'b0000000, -1, 1'b0, 8'd0, 1'b1};
        run_req(rv, -1, "ring2");
        use_ring = 1'b0;

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
